bqn_sort: RTL

//  Parametrised successor of the fixed 8x8-bit bq block. Loads N packed W-bit elements on a

---
 rtl/bqn_sort_pkg.sv | 25 ++
 rtl/bqn_sort_if.sv | 30 +++
 rtl/bqn_sort_cmpx.sv | 20 ++
 rtl/bqn_sort.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bqn_sort_pkg.sv
// Shared definitions for the bqn_sort odd-even transposition sorter.
//  - state_t  : control FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//  - clog2    : ceiling log2, usable in constant expressions
//  - sw_width : width of the swap counter for an N-element sort
package bqn_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Worst case is N*(N-1)/2 swaps (fully reversed input); N*N/2+1 bounds it.
  function automatic int sw_width(input int n);
    return clog2(n * n / 2 + 1);
  endfunction

endpackage

// File: rtl/bqn_sort_if.sv
// Request/result bundle between a controller and the bqn_sort tile.
//  start  : load request, taken only while the sorter is idle
//  x      : packed input, element i = x[i*W +: W]
//  busy   : sort in progress
//  done   : one-cycle pulse, y/nswap/d3 updated in the same cycle
//  y      : packed ascending result, element 0 = smallest
//  nswap  : number of compare-exchange swaps of the last sort
//  d3     : last input was already sorted (no swaps)
// master = controller side, slave = sorter side.
interface bqn_sort_if
  import bqn_sort_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) ();

  localparam int SW = sw_width(N);

  logic           start;
  logic [N*W-1:0] x;
  logic           busy;
  logic           done;
  logic [N*W-1:0] y;
  logic [SW-1:0]  nswap;
  logic           d3;

  modport master (output start, x, input busy, done, y, nswap, d3);
  modport slave  (input start, x, output busy, done, y, nswap, d3);

endinterface

// File: rtl/bqn_sort_cmpx.sv
// Combinational compare-exchange cell.
//  a, b : operands (unsigned, W bits)
//  lo   : smaller of the two, hi : larger
//  swp  : 1 when a > b, i.e. the pair was exchanged. Equal values are left
//         in place so the network is stable.
module bqn_sort_cmpx #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swp
);

  assign swp = (a > b);
  assign lo  = swp ? b : a;
  assign hi  = swp ? a : b;

endmodule

// File: rtl/bqn_sort.sv
// Iterative odd-even transposition sorter for N packed W-bit elements.
// One network phase per clock: even phases exchange (0,1),(2,3)..., odd
// phases exchange (1,2),(3,4)... A sort ends after N phases, or earlier
// (EARLY_EXIT=1) once two consecutive phases made no swap.
// Ports:
//  CLK  : rising-edge clock
//  nRST : asynchronous active-low reset
//  bus  : bqn_sort_if slave (start/x in; busy/done/y/nswap/d3 out)
module bqn_sort
  import bqn_sort_pkg::*;
#(
  parameter int N          = 8,
  parameter int W          = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  bqn_sort_if.slave  bus
);

  localparam int PW = clog2(N);
  localparam int SW = sw_width(N);
  localparam int NH = N / 2;

  state_t         state_reg;
  logic [PW-1:0]  phase_reg;
  logic [1:0]     quiet_reg;
  logic [SW-1:0]  cnt_reg;
  logic [W-1:0]   work_reg [N];

  logic           busy_reg;
  logic           done_reg;
  logic [N*W-1:0] y_reg;
  logic [SW-1:0]  nswap_reg;
  logic           d3_reg;

  // Candidate next arrays for both phase parities; phase_reg[0] picks one.
  logic [W-1:0]   ev_arr  [N];
  logic [W-1:0]   od_arr  [N];
  logic [W-1:0]   nxt_arr [N];
  logic [NH-1:0]  ev_swp;
  logic [NH-1:0]  od_swp;

  genvar gi;
  generate
    for (gi = 0; gi < NH; gi++) begin : g_pair
      bqn_sort_cmpx #(.W(W)) u_ev (
        .a   (work_reg[2*gi]),
        .b   (work_reg[2*gi+1]),
        .lo  (ev_arr[2*gi]),
        .hi  (ev_arr[2*gi+1]),
        .swp (ev_swp[gi])
      );
      // Odd phase has one pair fewer; the spare swap bit is tied off so
      // N==2 still works (odd phase does nothing but still counts).
      if (gi < NH - 1) begin : g_odd
        bqn_sort_cmpx #(.W(W)) u_od (
          .a   (work_reg[2*gi+1]),
          .b   (work_reg[2*gi+2]),
          .lo  (od_arr[2*gi+1]),
          .hi  (od_arr[2*gi+2]),
          .swp (od_swp[gi])
        );
      end else begin : g_odd_none
        assign od_swp[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_sel
      assign nxt_arr[gi] = phase_reg[0] ? od_arr[gi] : ev_arr[gi];
    end
  endgenerate

  // End elements are untouched by odd phases.
  assign od_arr[0]   = work_reg[0];
  assign od_arr[N-1] = work_reg[N-1];

  logic [NH-1:0] sel_swp;
  logic [SW-1:0] swaps;
  logic [SW:0]   cnt_sum;
  logic [SW-1:0] cnt_next;
  logic [1:0]    quiet_next;
  logic          finish;

  always_comb begin
    sel_swp = phase_reg[0] ? od_swp : ev_swp;
    swaps   = '0;
    for (int i = 0; i < NH; i++) begin
      swaps = swaps + SW'(sel_swp[i]);
    end
    cnt_sum  = {1'b0, cnt_reg} + {1'b0, swaps};
    cnt_next = cnt_sum[SW] ? '1 : cnt_sum[SW-1:0];
    if (swaps != '0) begin
      quiet_next = 2'd0;
    end else if (quiet_reg == 2'd3) begin
      quiet_next = 2'd3;
    end else begin
      quiet_next = quiet_reg + 2'd1;
    end
    // Two quiet phases in a row cover both parities, so the array is sorted.
    finish = (phase_reg == PW'(N - 1)) ||
             ((EARLY_EXIT != 0) && (quiet_next == 2'd2));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      quiet_reg <= '0;
      cnt_reg   <= '0;
      for (int i = 0; i < N; i++) work_reg[i] <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      y_reg     <= '0;
      nswap_reg <= '0;
      d3_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N; i++) work_reg[i] <= bus.x[i*W +: W];
            cnt_reg   <= '0;
            phase_reg <= '0;
            quiet_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < N; i++) work_reg[i] <= nxt_arr[i];
          cnt_reg   <= cnt_next;
          quiet_reg <= quiet_next;
          phase_reg <= phase_reg + 1'b1;
          if (finish) state_reg <= ST_DONE;
        end
        ST_DONE: begin
          // Results are published only here, so they hold through a sort.
          for (int i = 0; i < N; i++) y_reg[i*W +: W] <= work_reg[i];
          nswap_reg <= cnt_reg;
          d3_reg    <= (cnt_reg == '0);
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.y     = y_reg;
  assign bus.nswap = nswap_reg;
  assign bus.d3    = d3_reg;

endmodule
